// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, channel state encoding and configuration layout
// for the multi-channel PWM burst generator.
package pwm_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMES_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Configuration layout at the default widths, as seen by register-side logic.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]   period;
    logic [CNT_W_DEF-1:0]   high;
    logic [TIMES_W_DEF-1:0] times;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM burst channel with double-buffered configuration,
// period/burst counters and registered outputs.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMES_W = TIMES_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high,
  input  logic [TIMES_W-1:0] times,
  input  logic               inv,
  output logic               pwm,
  output logic               busy,
  output logic               done,
  output logic               state_dbg
);

  typedef struct packed {
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   high;
    logic [TIMES_W-1:0] times;
  } cfg_t;

  chan_state_e        state;
  chan_state_e        state_next;
  cfg_t               in_cfg;
  cfg_t               shadow;
  cfg_t               active;
  logic               pending;
  logic               en_d;
  logic               finished;
  logic [CNT_W-1:0]   period_cnt;
  logic [CNT_W-1:0]   last_cnt;
  logic [TIMES_W-1:0] times_cnt;
  logic               start;
  logic               abort;
  logic               wrap;
  logic               complete;
  logic               pwm_next;
  logic               busy_next;

  assign in_cfg    = {period, high, times};
  assign state_dbg = (state == RUN);

  // A programmed period of 0 behaves as a period of 1.
  assign last_cnt = (active.period == '0) ? '0 : active.period - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    wrap       = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (en && !en_d) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        wrap = (period_cnt == last_cnt);
        if (!en) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (wrap && (active.times != '0) &&
                     (times_cnt == active.times - TIMES_W'(1))) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // The waveform trails period_cnt by one clock; inversion is folded into the register.
  always_comb begin
    busy_next = (state == RUN);
    pwm_next  = ((state == RUN) && (period_cnt < active.high)) ^ inv;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      en_d       <= 1'b0;
      finished   <= 1'b0;
      period_cnt <= '0;
      times_cnt  <= '0;
      pwm        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      en_d     <= en;
      pwm      <= pwm_next;
      busy     <= busy_next;
      finished <= complete;
      done     <= finished;

      if (load) begin
        shadow  <= in_cfg;
        pending <= 1'b1;
      end

      if (start) begin
        active     <= load ? in_cfg : shadow;
        pending    <= 1'b0;
        period_cnt <= '0;
        times_cnt  <= '0;
      end else if (state == RUN) begin
        if (abort || complete) begin
          period_cnt <= '0;
          times_cnt  <= '0;
        end else if (wrap) begin
          period_cnt <= '0;
          // Continuous mode parks times_cnt at its maximum.
          if ((active.times != '0) || (times_cnt != '1)) begin
            times_cnt <= times_cnt + TIMES_W'(1);
          end
          // New configuration only ever lands on a period boundary.
          if (load || pending) begin
            active  <= load ? in_cfg : shadow;
            pending <= 1'b0;
          end
        end else begin
          period_cnt <= period_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_burst_mc.sv
// pwm_burst_mc: CH_NUM independent PWM burst channels on flattened buses.
// Define PWM_INV_EN to add the per-channel output inversion input i_inv.
module pwm_burst_mc
  import pwm_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMES_W = TIMES_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         i_en,
  input  logic [CH_NUM-1:0]         i_load,
  input  logic [CH_NUM*CNT_W-1:0]   i_period,
  input  logic [CH_NUM*CNT_W-1:0]   i_high,
  input  logic [CH_NUM*TIMES_W-1:0] i_times,
`ifdef PWM_INV_EN
  input  logic [CH_NUM-1:0]         i_inv,
`endif
  output logic [CH_NUM-1:0]         o_pwm,
  output logic [CH_NUM-1:0]         o_busy,
  output logic [CH_NUM-1:0]         o_done,
  output logic [CH_NUM-1:0]         dbg_state
);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic inv;
`ifdef PWM_INV_EN
    assign inv = i_inv[k];
`else
    assign inv = 1'b0;
`endif

    pwm_chan #(
      .CNT_W   (CNT_W),
      .TIMES_W (TIMES_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (i_en[k]),
      .load      (i_load[k]),
      .period    (i_period[k*CNT_W +: CNT_W]),
      .high      (i_high[k*CNT_W +: CNT_W]),
      .times     (i_times[k*TIMES_W +: TIMES_W]),
      .inv       (inv),
      .pwm       (o_pwm[k]),
      .busy      (o_busy[k]),
      .done      (o_done[k]),
      .state_dbg (dbg_state[k])
    );
  end

endmodule

// File: tb/tb_pwm_burst_mc.sv
// Self-checking bench for pwm_burst_mc: randomized bursts compared cycle by
// cycle against a per-channel trace built from period/high/times arithmetic.
module tb_pwm_burst_mc;

  localparam int CH      = 4;
  localparam int CNT_W   = 32;
  localparam int TIMES_W = 16;
  localparam int W       = 4 * CH;
  localparam int MAXT    = 256;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        i_en;
  logic [CH-1:0]        i_load;
  logic [CH*CNT_W-1:0]  i_period;
  logic [CH*CNT_W-1:0]  i_high;
  logic [CH*TIMES_W-1:0] i_times;
`ifdef PWM_INV_EN
  logic [CH-1:0]        i_inv;
`endif
  logic [CH-1:0]        o_pwm;
  logic [CH-1:0]        o_busy;
  logic [CH-1:0]        o_done;
  logic [CH-1:0]        dbg_state;

  // Expected per-cycle vector {state, done, busy, pwm}, each CH bits wide.
  logic [W-1:0] exp_q[$];
  logic [3:0]   tr[CH][MAXT];
  logic [CH-1:0] inv_v;
  int n_tests;
  int n_fail;

  pwm_burst_mc #(.CH_NUM(CH), .CNT_W(CNT_W), .TIMES_W(TIMES_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_load    (i_load),
    .i_period  (i_period),
    .i_high    (i_high),
    .i_times   (i_times),
`ifdef PWM_INV_EN
    .i_inv     (i_inv),
`endif
    .o_pwm     (o_pwm),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int k, input int unsigned p, input int unsigned h,
                         input int unsigned tm);
    i_period[k*CNT_W +: CNT_W]     = p;
    i_high[k*CNT_W +: CNT_W]       = h;
    i_times[k*TIMES_W +: TIMES_W]  = tm[TIMES_W-1:0];
  endtask

  task automatic idle_cycles(input int n);
    i_en   = '0;
    i_load = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int k = 0; k < CH; k++)
      for (int t = 0; t < MAXT; t++) tr[k][t] = '0;
    exp_q.delete();
  endtask

  // Burst whose rising enable is sampled at edge s.
  task automatic model_burst(input int k, input int s, input int unsigned p,
                             input int unsigned h, input int unsigned tm);
    int unsigned pe;
    int len;
    pe  = (p == 0) ? 1 : p;
    len = int'(tm * pe);
    tr[k][s] = 4'b1000;
    for (int i = 0; i < len; i++)
      tr[k][s+1+i] = {(i < len - 1), 1'b0, 1'b1, ((i % pe) < h)};
    tr[k][s+1+len] = 4'b0100;
  endtask

  // Continuous run started at edge s, enable sampled low at edge a.
  task automatic model_run(input int k, input int s, input int a, input int unsigned p,
                           input int unsigned h);
    int unsigned pe;
    pe = (p == 0) ? 1 : p;
    tr[k][s] = 4'b1000;
    for (int t = s + 1; t <= a; t++)
      tr[k][t] = {(t < a), 1'b0, 1'b1, ((int'(t - s - 1) % pe) < h)};
  endtask

  task automatic model_push(input int n);
    logic [W-1:0] v;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < CH; k++) begin
        v[k]        = tr[k][t][0] ^ inv_v[k];
        v[CH+k]     = tr[k][t][1];
        v[2*CH+k]   = tr[k][t][2];
        v[3*CH+k]   = tr[k][t][3];
      end
      exp_q.push_back(v);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] obs;
    rst = 1'b0;
    i_en = '0;
    i_load = '0;
    i_period = '0;
    i_high = '0;
    i_times = '0;
`ifdef PWM_INV_EN
    i_inv = '1;
`endif
    #3;
    obs = {dbg_state, o_done, o_busy, o_pwm};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_async got %h expected %h", obs, {W{1'b0}});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {dbg_state, o_done, o_busy, o_pwm};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got %h expected %h", obs, {W{1'b0}});
    end
    rst = 1'b1;
`ifdef PWM_INV_EN
    i_inv = '0;
`endif
    @(posedge clk);
    @(negedge clk);
    obs = {dbg_state, o_done, o_busy, o_pwm};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_release got %h expected %h", obs, {W{1'b0}});
    end
  endtask

  task automatic test_basic();
    int unsigned p2, h2, t2;
    int st2, n;
    logic [W-1:0] exp_v, obs;
    p2 = $urandom_range(1, 9);
    h2 = $urandom_range(0, 10);
    t2 = $urandom_range(1, 3);
    st2 = 42;
    model_clear();
    model_burst(0, 0, 10, 3, 4);
    model_burst(0, st2, p2, h2, t2);
    model_push(st2 + int'(t2 * p2) + 6);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        set_cfg(0, 10, 3, 4);
        i_load[0] = 1'b1;
        i_en[0] = 1'b1;
      end
      if (t == 41) begin
        i_en[0] = 1'b0;
        set_cfg(0, p2, h2, t2);
        i_load[0] = 1'b1;
      end
      if (t == st2) i_en[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_continuous_abort();
    int unsigned p1, h1;
    int a0, a1, n;
    logic [W-1:0] exp_v, obs;
    p1 = $urandom_range(1, 7);
    h1 = $urandom_range(0, 8);
    a1 = $urandom_range(20, 60);
    a0 = 100 + $urandom_range(1, 4);
    model_clear();
    model_run(0, 0, a0, 5, 2);
    model_run(1, 0, a1, p1, h1);
    model_push(a0 + 4);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        set_cfg(0, 5, 2, 0);
        set_cfg(1, p1, h1, 0);
        i_load = 4'b0011;
        i_en = 4'b0011;
      end
      if (t == a1) i_en[1] = 1'b0;
      if (t == a0) i_en[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL cont_abort t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_update();
    int unsigned h0, h1, h2, pc, hc;
    int a, t, pi, n;
    logic [W-1:0] exp_v, obs;
    h0 = $urandom_range(1, 3);
    h1 = $urandom_range(4, 7);
    h2 = $urandom_range(0, 4);
    a = 32 + 5 * 3 + 2;
    model_clear();
    // Loads at edges 11/13 land on period 2; the load at edge 32 lands on period 4.
    tr[0][0] = 4'b1000;
    t = 1;
    pi = 0;
    while (t <= a) begin
      pc = (pi < 4) ? 8 : 5;
      hc = (pi < 2) ? h0 : (pi < 4) ? h1 : h2;
      for (int c = 0; c < int'(pc) && t <= a; c++) begin
        tr[0][t] = {(t < a), 1'b0, 1'b1, (c < int'(hc))};
        t++;
      end
      pi++;
    end
    model_push(a + 3);
    n = exp_q.size();
    for (int s = 0; s < n; s++) begin
      i_load = '0;
      if (s == 0) begin
        set_cfg(0, 8, h0, 0);
        i_load[0] = 1'b1;
        i_en[0] = 1'b1;
      end
      if (s == 11) begin
        set_cfg(0, 8, 7, 0);
        i_load[0] = 1'b1;
      end
      if (s == 13) begin
        set_cfg(0, 8, h1, 0);
        i_load[0] = 1'b1;
      end
      if (s == 32) begin
        set_cfg(0, 5, h2, 0);
        i_load[0] = 1'b1;
      end
      if (s == a) i_en[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL update t=%0d got %h expected %h", s, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_edges();
    int n;
    logic [W-1:0] exp_v, obs;
    model_clear();
    model_burst(0, 0, 7, 0, 2);
    model_burst(1, 0, 10, 20, 2);
    model_burst(2, 0, 0, 1, 3);
    model_burst(3, 0, 4, 4, 2);
    model_push(24);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        set_cfg(0, 7, 0, 2);
        set_cfg(1, 10, 20, 2);
        set_cfg(2, 0, 1, 3);
        set_cfg(3, 4, 4, 2);
        i_load = '1;
        i_en = '1;
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL edges t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_independent();
    int unsigned p[CH], h[CH], tm[CH];
    int off[CH];
    int n;
    logic [W-1:0] exp_v, obs;
    model_clear();
    n = 0;
    for (int k = 0; k < CH; k++) begin
      p[k]   = $urandom_range(1, 12);
      h[k]   = $urandom_range(0, 13);
      tm[k]  = $urandom_range(1, 3);
      off[k] = $urandom_range(0, 3);
      model_burst(k, off[k], p[k], h[k], tm[k]);
      if (off[k] + int'(tm[k] * p[k]) + 4 > n) n = off[k] + int'(tm[k] * p[k]) + 4;
    end
    model_push(n);
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        for (int k = 0; k < CH; k++) set_cfg(k, p[k], h[k], tm[k]);
        i_load = '1;
      end
      for (int k = 0; k < CH; k++) if (t == off[k]) i_en[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL independent t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    int unsigned p[CH], h[CH];
    int n;
    logic [W-1:0] exp_v, obs;
    model_clear();
    for (int k = 0; k < CH; k++) begin
      p[k] = $urandom_range(3, 8);
      h[k] = $urandom_range(1, p[k]);
      model_burst(k, 0, p[k], h[k], 3);
    end
    model_push(10);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        for (int k = 0; k < CH; k++) set_cfg(k, p[k], h[k], 3);
        i_load = '1;
        i_en = '1;
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_pre t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    i_load = '0;
    #2 rst = 1'b0;
    #1;
    obs = {dbg_state, o_done, o_busy, o_pwm};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got %h expected %h", obs, {W{1'b0}});
    end
    i_en = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      @(negedge clk);
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_no_restart t=%0d got %h expected %h", t, obs, {W{1'b0}});
      end
    end
    model_clear();
    for (int k = 0; k < CH; k++) model_burst(k, 0, 4, 1, 2);
    model_push(12);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        for (int k = 0; k < CH; k++) set_cfg(k, 4, 1, 2);
        i_load = '1;
        i_en = '1;
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_restart t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    idle_cycles(2);
  endtask

`ifdef PWM_INV_EN
  task automatic test_inv();
    int n;
    logic [W-1:0] exp_v, obs;
    inv_v = 4'b0010;
    i_inv = inv_v;
    idle_cycles(1);
    model_clear();
    model_burst(0, 0, 6, 2, 2);
    model_burst(1, 0, 6, 2, 2);
    model_push(16);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      i_load = '0;
      if (t == 0) begin
        set_cfg(0, 6, 2, 2);
        set_cfg(1, 6, 2, 2);
        i_load = 4'b0011;
        i_en = 4'b0011;
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs = {dbg_state, o_done, o_busy, o_pwm};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL inv t=%0d got %h expected %h", t, obs, exp_v);
      end
    end
    inv_v = '0;
    i_inv = '0;
    idle_cycles(2);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    inv_v   = '0;
    test_reset();
    test_basic();
    test_continuous_abort();
    test_update();
    test_edges();
    test_independent();
    test_reset_mid();
`ifdef PWM_INV_EN
    test_inv();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_burst_mc.md
# pwm_burst_mc

Multi-channel PWM burst generator: each of `CH_NUM` independent channels emits `times` periods of a PWM waveform, with programmable period and high time, or runs continuously. Configuration is double-buffered and takes effect only on period boundaries, so updates never produce glitches. The block sits between the register/control logic and the pad or driver outputs, and supersedes the single-channel fixed-width PWM primitive.

## Interface
Parameters:
- `CH_NUM`, 4: number of channels.
- `CNT_W`, 32: width of the period and high-time counters.
- `TIMES_W`, 16: width of the burst-count field.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_en` in `CH_NUM`: per-channel enable. A rising edge starts a burst; low aborts it.
- `i_load` in `CH_NUM`: per-channel one-cycle strobe that captures configuration into the shadow registers.
- `i_period` in `CH_NUM*CNT_W`: period in clocks. Channel k is at `[k*CNT_W +: CNT_W]`.
- `i_high` in `CH_NUM*CNT_W`: high time in clocks.
- `i_times` in `CH_NUM*TIMES_W`: burst length in periods. 0 means continuous.
- `o_pwm` out `CH_NUM`: PWM outputs, registered.
- `o_busy` out `CH_NUM`: channel is in RUN, registered.
- `o_done` out `CH_NUM`: one-cycle pulse when a burst completes normally.

## Operation
- Per-channel registers:
  - shadow {period, high, times} plus a pending flag;
  - active {period, high, times};
  - `en_d` (previous `i_en`);
  - `period_cnt` (`CNT_W` bits);
  - `times_cnt` (`TIMES_W` bits);
  - state.
- `i_load[k]` writes the shadow registers and sets pending. A new load before the apply overwrites the shadow; the last load wins.
- States:
  - IDLE: counters held at 0, `o_pwm` at idle level.
  - IDLE→RUN when `i_en[k]=1 && en_d[k]=0`. Shadow values (or the inputs directly, if `i_load` is in the same cycle) are copied to active. pending clears, counters clear.
  - RUN→IDLE on completion, when active `times != 0`, `period_cnt == period-1` and `times_cnt == times-1`. `o_done` pulses.
  - RUN→IDLE on abort, when `i_en[k]=0` in any cycle. No `o_done`. Counters clear.
- In RUN, `period_cnt` counts 0..period-1 and then wraps. `times_cnt` increments on each wrap. In continuous mode it saturates at max and is ignored.
- At each wrap, if pending is set, shadow is copied to active and pending clears. If `i_load` coincides with the wrap, the new input values are applied directly.
- Output rule: `o_pwm` next = RUN && (`period_cnt < high`). Comparisons are unsigned, full `CNT_W`.
- Edge cases:
  - period 0 is treated as 1.
  - high 0 gives constant low.
  - high ≥ period gives constant high during the burst.
- Channels are fully independent. There is no cross-channel synchronisation.

## Timing
- Reset values: `o_pwm=0` (also 0 with inversion enabled; see Configuration), `o_busy=0`, `o_done=0`, all counters, shadow, active and `en_d` = 0, state IDLE.
- Start latency:
  - `i_en` first sampled high at edge E0.
  - State is RUN and `period_cnt=0` after E0.
  - `o_busy` and the first `o_pwm` high cycle appear after E1.
  - The waveform lags `period_cnt` by one clock.
- A burst gives exactly `times*period` cycles of output activity, with `high` high cycles per period.
- Completion: after the last counted cycle, `o_busy` falls and `o_done` pulses for one cycle, both registered and in the same cycle.
- Abort: `o_busy` and `o_pwm` return to idle one clock after `i_en` is sampled low.
- `i_en` held high after completion does not restart the channel; a fresh rising edge is required.
- Reset asserted mid-burst forces the reset values immediately (asynchronously).

## Configuration
- `PWM_INV_EN` defined:
  - adds port `i_inv` in `CH_NUM`, per-channel output inversion;
  - `o_pwm[k]` = internal waveform XOR `i_inv[k]`, including the idle level;
  - `i_inv` is sampled every cycle and is not shadowed;
  - reset value remains 0.
- `PWM_INV_EN` undefined: the port is absent and outputs are active-high with idle level 0.

## Structure
- Package `pwm_pkg`:
  - default `CNT_W` / `TIMES_W` constants;
  - channel state enum {IDLE, RUN};
  - config struct {period, high, times}.
- Sub-module `pwm_chan`: one channel, holding the FSM, shadow/active registers, counters and output register. The top level generates `CH_NUM` instances and slices the flattened buses.

## Test plan
- Basic burst: ch0 period=10, high=3, times=4, rising `i_en` → 4 periods of 3 high / 7 low, `o_busy` high for 40 cycles, single `o_done` pulse as `o_busy` falls, then `o_pwm=0`.
- Continuous and abort: times=0, period=5, high=2, run 100 cycles, drop `i_en` mid-period → output idle 1 clock later, no `o_done`.
- Glitch-free update: running period=8, high=2; `i_load` period=8, high=6 mid-period → current period keeps 2 high, next period shows 6 high. A load exactly at the wrap cycle applies at that wrap.
- Edge values: high=0 → constant low for the burst. high=20 with period=10 → constant high. period=0 with high=1 → constant high, treated as period 1.
- Independence and reset: ch0–ch3 with different configurations started together → each matches its own expectation. Assert `rst` mid-burst → all outputs 0 asynchronously, and restart requires a new `i_en` edge.
- `PWM_INV_EN`: `i_inv[1]=1` → ch1 idle high and waveform inverted; other channels unaffected.
